// File: rtl/nlm_pe_acc_ctrl.sv
`default_nettype none
// ============================================================================
// nlm_pe_acc_ctrl : time-multiplexed sequencer for one NLM weighted-accumulate
//                   PE, producing one weight/pixel sum pair per window.
// Revision        : 1.0
// ============================================================================
module nlm_pe_acc_ctrl #(
  parameter  int DATA_WIDTH       = 12,
  parameter  int SRH_LENGTH       = 13,
  parameter  int WEIGHT_WIDTH     = 8,
  localparam int WIN_SIZE         = ((SRH_LENGTH + 1) / 2) * ((SRH_LENGTH + 1) / 2),
  localparam int WEIGHT_SUM_WIDTH = WEIGHT_WIDTH + $clog2(WIN_SIZE),
  localparam int PIX_SUM_WIDTH    = WEIGHT_SUM_WIDTH + DATA_WIDTH,
  localparam int CNT_WIDTH        = $clog2(WIN_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        abort_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [WEIGHT_WIDTH-1:0]     in_weight_i,
  input  logic [DATA_WIDTH-1:0]       in_pix_i,
  output logic [WEIGHT_WIDTH-1:0]     pe_weight_o,
  output logic [DATA_WIDTH-1:0]       pe_srh_bit_o,
  output logic [WEIGHT_SUM_WIDTH-1:0] pe_weight_sum_o,
  output logic [PIX_SUM_WIDTH-1:0]    pe_pix_sum_o,
  input  logic [WEIGHT_SUM_WIDTH-1:0] pe_weight_sum_i,
  input  logic [PIX_SUM_WIDTH-1:0]    pe_pix_sum_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [WEIGHT_SUM_WIDTH-1:0] out_weight_sum_o,
  output logic [PIX_SUM_WIDTH-1:0]    out_pix_sum_o,
  output logic [CNT_WIDTH-1:0]        win_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] C_LAST_CNT = CNT_WIDTH'(WIN_SIZE - 1);

  typedef enum logic [0:0] {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic                        first_q, first_d;
  logic                        out_valid_q, out_valid_d;
  logic [WEIGHT_SUM_WIDTH-1:0] out_wsum_q, out_wsum_d;
  logic [PIX_SUM_WIDTH-1:0]    out_psum_q, out_psum_d;

  logic last_stall;
  logic accept;
  logic zero_fb;

  always_comb begin
    // The last sample may only enter when the result register will be free at DRAIN.
    last_stall   = (cnt_q == C_LAST_CNT) && out_valid_q && !out_ready_i;
    in_ready_o   = (state_q == ST_ACC) && !abort_i && !last_stall;
    accept       = in_valid_i && in_ready_o;

    // The PE accumulates every clock, so an idle cycle must feed a zero product.
    pe_weight_o  = accept ? in_weight_i : '0;
    pe_srh_bit_o = accept ? in_pix_i    : '0;

    zero_fb         = first_q && (state_q == ST_ACC);
    pe_weight_sum_o = zero_fb ? '0 : pe_weight_sum_i;
    pe_pix_sum_o    = zero_fb ? '0 : pe_pix_sum_i;

    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_wsum_d  = out_wsum_q;
    out_psum_d  = out_psum_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_ACC: begin
        if (abort_i) begin
          cnt_d   = '0;
          first_d = 1'b1;
        end else if (accept) begin
          if (cnt_q == C_LAST_CNT) begin
            cnt_d   = '0;
            first_d = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            cnt_d   = cnt_q + CNT_WIDTH'(1);
            first_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        out_wsum_d  = pe_weight_sum_i;
        out_psum_d  = pe_pix_sum_i;
        out_valid_d = 1'b1;
        state_d     = ST_ACC;
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      cnt_q       <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_wsum_q  <= '0;
      out_psum_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_wsum_q  <= out_wsum_d;
      out_psum_q  <= out_psum_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_weight_sum_o = out_wsum_q;
  assign out_pix_sum_o    = out_psum_q;
  assign win_cnt_o        = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_nlm_pe_acc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_nlm_pe_acc_ctrl : randomized + directed bench with a window-level model.
// Revision           : 1.0
// ============================================================================
module tb_nlm_pe_acc_ctrl;

  localparam int DW  = 12;
  localparam int WW  = 8;
  localparam int WIN = 49;
  localparam int WSW = 14;
  localparam int PSW = 26;
  localparam int CW  = 6;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           abort_i = 1'b0;
  logic           in_valid_i = 1'b0;
  logic           in_ready_o;
  logic [WW-1:0]  in_weight_i = '0;
  logic [DW-1:0]  in_pix_i = '0;
  logic [WW-1:0]  pe_weight_o;
  logic [DW-1:0]  pe_srh_bit_o;
  logic [WSW-1:0] pe_weight_sum_o;
  logic [PSW-1:0] pe_pix_sum_o;
  logic [WSW-1:0] pe_ws_q;
  logic [PSW-1:0] pe_ps_q;
  logic           out_valid_o;
  logic           out_ready_i = 1'b0;
  logic [WSW-1:0] out_weight_sum_o;
  logic [PSW-1:0] out_pix_sum_o;
  logic [CW-1:0]  win_cnt_o;

  nlm_pe_acc_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .abort_i          (abort_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_weight_i      (in_weight_i),
    .in_pix_i         (in_pix_i),
    .pe_weight_o      (pe_weight_o),
    .pe_srh_bit_o     (pe_srh_bit_o),
    .pe_weight_sum_o  (pe_weight_sum_o),
    .pe_pix_sum_o     (pe_pix_sum_o),
    .pe_weight_sum_i  (pe_ws_q),
    .pe_pix_sum_i     (pe_ps_q),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_weight_sum_o (out_weight_sum_o),
    .out_pix_sum_o    (out_pix_sum_o),
    .win_cnt_o        (win_cnt_o)
  );

  always #5 clk = ~clk;

  // PE stand-in: registers feed + weight*pix every clock, no enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_ws_q <= '0;
      pe_ps_q <= '0;
    end else begin
      pe_ws_q <= pe_weight_sum_o + WSW'(pe_weight_o);
      pe_ps_q <= pe_pix_sum_o + PSW'(pe_weight_o) * PSW'(pe_srh_bit_o);
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Window-level model: running sums of w*p, a pending completed window, and a result slot.
  int     m_cnt;
  longint m_ws, m_ps;
  bit     m_drain;
  longint m_dw, m_dp;
  bit     m_ov;
  longint m_ow, m_op;

  function automatic bit exp_ready();
    return !m_drain && !abort_i && !(m_cnt == WIN - 1 && m_ov && !out_ready_i);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit acc;
    if (!rst_n) begin
      m_cnt = 0; m_ws = 0; m_ps = 0;
      m_drain = 0; m_dw = 0; m_dp = 0;
      m_ov = 0; m_ow = 0; m_op = 0;
    end else begin
      acc = in_valid_i && exp_ready();
      if (m_ov && out_ready_i) m_ov = 0;
      if (m_drain) begin
        m_ov = 1; m_ow = m_dw; m_op = m_dp; m_drain = 0;
      end else if (abort_i) begin
        m_cnt = 0; m_ws = 0; m_ps = 0;
      end else if (acc) begin
        m_ws += longint'(in_weight_i);
        m_ps += longint'(in_weight_i) * longint'(in_pix_i);
        m_cnt++;
        if (m_cnt == WIN) begin
          m_drain = 1; m_dw = m_ws; m_dp = m_ps;
          m_cnt = 0; m_ws = 0; m_ps = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit er;
    bit acc;
    if (rst_n && chk_en) begin
      er  = exp_ready();
      acc = in_valid_i && er;
      chk("in_ready", in_ready_o, er);
      chk("pe_weight", pe_weight_o, acc ? in_weight_i : 8'd0);
      chk("pe_srh_bit", pe_srh_bit_o, acc ? in_pix_i : 12'd0);
      chk("win_cnt", win_cnt_o, m_cnt);
      chk("out_valid", out_valid_o, m_ov);
      chk("out_weight_sum", out_weight_sum_o, m_ow);
      chk("out_pix_sum", out_pix_sum_o, m_op);
      if (m_drain) begin
        chk("pe_final_wsum", pe_ws_q, m_dw);
        chk("pe_final_psum", pe_ps_q, m_dp);
      end else if (m_cnt > 0) begin
        chk("pe_hold_wsum", pe_ws_q, m_ws);
        chk("pe_hold_psum", pe_ps_q, m_ps);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic push(input int w, input int p);
    bit got;
    int tries;
    got = 1'b0;
    tries = 0;
    in_valid_i  = 1'b1;
    in_weight_i = WW'(w);
    in_pix_i    = DW'(p);
    while (!got && tries < 300) begin
      @(negedge clk);
      got = in_ready_o;
      step();
      tries++;
    end
    in_valid_i = 1'b0;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: got no accept expected accept within 300 cycles");
    end
  endtask

  task automatic send_window(input int n, input int w, input int p, input int gmax);
    for (int i = 0; i < n; i++) begin
      if (gmax > 0) idle($urandom_range(0, gmax));
      push(w, p);
    end
  endtask

  task automatic wait_valid();
    int c;
    c = 0;
    while (!out_valid_o && c < 300) begin
      step();
      c++;
    end
    if (!out_valid_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_valid_timeout: got out_valid 0 expected 1 within 300 cycles");
    end
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_win_cnt", win_cnt_o, 0);
    chk("rst_out_wsum", out_weight_sum_o, 0);
    chk("rst_out_psum", out_pix_sum_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk_en = 1'b1;

    // Back-to-back window, exact latency.
    out_ready_i = 1'b1;
    send_window(WIN, 1, 100, 0);
    chk("drain_in_ready", in_ready_o, 0);
    chk("drain_out_valid", out_valid_o, 0);
    chk("drain_win_cnt", win_cnt_o, 0);
    step();
    chk("lat_out_valid", out_valid_o, 1);
    chk("w1_wsum", out_weight_sum_o, 49);
    chk("w1_psum", out_pix_sum_o, 4900);
    idle(2);

    // Gapped input.
    send_window(WIN, 1, 100, 3);
    wait_valid();
    chk("gap_wsum", out_weight_sum_o, 49);
    chk("gap_psum", out_pix_sum_o, 4900);
    idle(2);

    // Full-scale window.
    send_window(WIN, 255, 4095, 0);
    wait_valid();
    chk("max_wsum", out_weight_sum_o, 12495);
    chk("max_psum", out_pix_sum_o, 51167025);
    idle(2);

    // Backpressure across two windows.
    out_ready_i = 1'b0;
    send_window(WIN, 1, 100, 0);
    send_window(WIN - 1, 2, 10, 0);
    in_valid_i  = 1'b1;
    in_weight_i = 8'd2;
    in_pix_i    = 12'd10;
    repeat (3) begin
      chk("stall_in_ready", in_ready_o, 0);
      chk("stall_win_cnt", win_cnt_o, 48);
      chk("held_wsum", out_weight_sum_o, 49);
      chk("held_psum", out_pix_sum_o, 4900);
      step();
    end
    out_ready_i = 1'b1;
    #1;
    chk("release_in_ready", in_ready_o, 1);
    step();
    in_valid_i = 1'b0;
    chk("consumed_valid", out_valid_o, 0);
    step();
    chk("bp2_valid", out_valid_o, 1);
    chk("bp2_wsum", out_weight_sum_o, 98);
    chk("bp2_psum", out_pix_sum_o, 980);
    idle(2);

    // Abort a partial window.
    send_window(20, 3, 7, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_win_cnt", win_cnt_o, 0);
    send_window(WIN, 2, 10, 0);
    wait_valid();
    chk("post_abort_wsum", out_weight_sum_o, 98);
    chk("post_abort_psum", out_pix_sum_o, 980);
    idle(2);

    // Reset mid-window, then with a pending result.
    send_window(30, 1, 100, 0);
    chk("mid_win_cnt", win_cnt_o, 30);
    rst_n = 1'b0;
    #1;
    chk("rst1_win_cnt", win_cnt_o, 0);
    chk("rst1_out_valid", out_valid_o, 0);
    step();
    rst_n = 1'b1;
    out_ready_i = 1'b0;
    send_window(WIN, 1, 100, 0);
    wait_valid();
    rst_n = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid_o, 0);
    chk("rst2_out_wsum", out_weight_sum_o, 0);
    chk("rst2_out_psum", out_pix_sum_o, 0);
    step();
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    send_window(WIN, 1, 100, 0);
    wait_valid();
    chk("post_rst_wsum", out_weight_sum_o, 49);
    chk("post_rst_psum", out_pix_sum_o, 4900);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      in_valid_i  = ($urandom_range(0, 99) < 70);
      in_weight_i = WW'($urandom);
      in_pix_i    = DW'($urandom);
      out_ready_i = ($urandom_range(0, 99) < 60);
      abort_i     = ($urandom_range(0, 999) < 5);
      step();
    end
    in_valid_i = 1'b0;
    abort_i    = 1'b0;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nlm_pe_acc_ctrl.md
Name: nlm_pe_acc_ctrl

Overview:
- Sequencer for a single NLM weighted-accumulate PE, reused WIN_SIZE times per output pixel (time-multiplexed instead of a spatial chain).
- Accepts a valid/ready stream of (weight, search-pixel) pairs and drives the PE's weight, pixel and sum inputs.
- Closes the PE's sum feedback loop and clears it at each window start; holds the PE when no sample is accepted.
- Captures the final weight/pixel sums into an output register with a valid/ready handshake, for the downstream divider.

Parameters:
- DATA_WIDTH, 12, search-pixel width.
- SRH_LENGTH, 13, search span; WIN_SIZE = ((SRH_LENGTH+1)/2)^2 = 49.
- WEIGHT_WIDTH, 8, weight width.
- WEIGHT_SUM_WIDTH, derived WEIGHT_WIDTH+$clog2(WIN_SIZE) = 14.
- PIX_SUM_WIDTH, derived WEIGHT_SUM_WIDTH+DATA_WIDTH = 26.
- CNT_WIDTH, derived $clog2(WIN_SIZE) = 6.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- abort_i  in  1  synchronous flush of the partial window.
- in_valid_i  in  1  sample valid.
- in_ready_o  out  1  sample accepted when in_valid_i && in_ready_o.
- in_weight_i  in  WEIGHT_WIDTH  sample weight.
- in_pix_i  in  DATA_WIDTH  search pixel.
- pe_weight_o  out  WEIGHT_WIDTH  to PE weight_i.
- pe_srh_bit_o  out  DATA_WIDTH  to PE srh_bit_i.
- pe_weight_sum_o  out  WEIGHT_SUM_WIDTH  to PE weight_sum_i.
- pe_pix_sum_o  out  PIX_SUM_WIDTH  to PE pix_sum_i.
- pe_weight_sum_i  in  WEIGHT_SUM_WIDTH  from PE weight_sum_o.
- pe_pix_sum_i  in  PIX_SUM_WIDTH  from PE pix_sum_o.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream ready.
- out_weight_sum_o  out  WEIGHT_SUM_WIDTH  window weight sum.
- out_pix_sum_o  out  PIX_SUM_WIDTH  window weighted pixel sum.
- win_cnt_o  out  CNT_WIDTH  samples accepted in the current window.

Behaviour:
- Reset: rst_n asynchronous active-low, clock clk. All registers clear: state ACC, cnt 0, first 1, out_valid_o 0, out sums 0.
- PE model: the PE registers feed + weight*pix every clock and has no enable. The controller therefore must feed weight 0 (pixel 0) whenever no sample is accepted. The feedback then holds the sum.
- Sum feed mux:
  - pe_*_sum_o = 0 when first==1.
  - Otherwise pe_*_sum_o = pe_*_sum_i (feedback).
  - All pe_* outputs are combinational.
- State ACC:
  - in_ready_o = 1 && !abort_i && !(cnt==WIN_SIZE-1 && out_valid_o && !out_ready_i).
  - On accept: pe_weight_o = in_weight_i, pe_srh_bit_o = in_pix_i, cnt++, first <= 0.
  - On accept with cnt==WIN_SIZE-1: cnt <= 0, first <= 1, go to DRAIN.
- State DRAIN (one cycle):
  - in_ready_o = 0; PE fed weight 0 plus feedback.
  - PE outputs now hold the final sums. Register them into out_*_sum_o, set out_valid_o, return to ACC.
  - The last-sample guard above guarantees the output register is free at this point.
- Latency: out_valid_o rises 2 cycles after the last-sample accept edge.
- Throughput: 1 window per WIN_SIZE+1 cycles at full rate. The next window may start while the previous result awaits out_ready_i.
- Output: out_valid_o clears on out_valid_o && out_ready_i. Data is stable while valid && !ready.
  - Simultaneous DRAIN capture and consume cannot occur (guard ensures empty).
- abort_i (ACC):
  - cnt <= 0, first <= 1, sample not accepted (in_ready_o low that cycle).
  - Output register unaffected.
  - abort_i during DRAIN is ignored (window already complete).
- Width: sums never overflow. 49*255 = 12495 < 2^14; 12495*4095 = 51,167,025 < 2^26.
- win_cnt_o = cnt. It is 0 during DRAIN and right after abort.

Test Plan:
- 49 samples, weight 1, pix 100, back-to-back -> out_weight_sum 49, out_pix_sum 4900, out_valid 2 cycles after the 49th accept; in_ready low exactly in DRAIN.
- Same window with random in_valid gaps (0-3 idle cycles) -> identical 49/4900; PE sums unchanged across idle cycles.
- 49 samples, weight 255, pix 4095 -> 12495 / 51,167,025, no overflow.
- out_ready held 0, two windows (w=1 p=100, then w=2 p=10) -> first result held stable; second window stalls with win_cnt 48, in_ready 0. Release out_ready -> results 49/4900 then 98/980.
- Abort after 20 samples (w=3 p=7), then full window w=2 p=10 -> no output for the aborted window; result 98/980.
- rst_n asserted mid-window (cnt 30) and with out_valid pending -> all outputs 0 immediately; next full window w=1 p=100 -> 49/4900.
